// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline control for the 5-stage WISC core.
// Handles operand forwarding select, load-use and flag-hazard stalls, data-memory
// freeze, taken-branch flushes and the halt-drain sequence. It drives the enables
// and flush/bubble controls of the PC and the four pipeline registers.
// Optional feature: define PIPE_CTRL_PERF_EN to add saturating stall/flush
// performance counters (perf_stall_cnt, perf_flush_cnt).
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 4,
    parameter int NUM_SRC   = 2,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_use,
    input  logic                        id_branch,
    input  logic                        id_br_taken,
    input  logic                        id_halt,
    input  logic                        ex_valid,
    input  logic                        ex_memread,
    input  logic                        ex_regwrite,
    input  logic                        ex_flag_set,
    input  logic [REG_AW-1:0]           ex_dst,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
    input  logic                        mem_valid,
    input  logic                        mem_regwrite,
    input  logic [REG_AW-1:0]           mem_dst,
    input  logic                        mem_busy,
    input  logic                        wb_regwrite,
    input  logic [REG_AW-1:0]           wb_dst,
    output logic                        pc_wen,
    output logic                        if_id_wen,
    output logic                        id_ex_wen,
    output logic                        ex_mem_wen,
    output logic                        mem_wb_wen,
    output logic                        if_id_flush,
    output logic                        id_ex_bubble,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        hlt
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]            perf_stall_cnt,
    output logic [CNT_W-1:0]            perf_flush_cnt
`endif
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [NUM_SRC-1:0]   use_hit;
    logic                 load_use;
    logic                 flag_haz;
    logic                 stall;
    logic                 taken;
    logic                 halt_accept;

    // Reject parameter values that would make the counters or drain logic meaningless.
    if (CNT_W < 1 || DRAIN_CYC < 1 || NUM_SRC < 1 || REG_AW < 1) begin : g_param_check
        $error("pipe_hazard_ctrl: CNT_W, DRAIN_CYC, NUM_SRC and REG_AW must all be >= 1");
    end

    // Per-operand forwarding select and load-use compare; register 0 never matches.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_AW-1:0] ex_s;
        logic [REG_AW-1:0] id_s;
        logic              mem_hit;
        logic              wb_hit;

        assign ex_s    = ex_src[g*REG_AW +: REG_AW];
        assign id_s    = id_src[g*REG_AW +: REG_AW];
        assign mem_hit = mem_valid & mem_regwrite & (mem_dst != '0) & (mem_dst == ex_s);
        assign wb_hit  = wb_regwrite & (wb_dst != '0) & (wb_dst == ex_s);
        assign fwd_sel[2*g +: 2] = rst     ? 2'b00 :
                                   mem_hit ? 2'b10 :
                                   wb_hit  ? 2'b01 : 2'b00;
        assign use_hit[g] = id_src_use[g] & (id_s != '0) & (id_s == ex_dst);
    end

    assign load_use    = id_valid & ex_valid & ex_memread & ex_regwrite & (|use_hit);
    assign flag_haz    = id_valid & id_branch & ex_valid & ex_flag_set;
    assign stall       = load_use | flag_haz;
    assign taken       = id_valid & id_br_taken;
    assign halt_accept = (state == RUN) & id_valid & id_halt & ~mem_busy & ~stall;

    // Enable/flush/bubble decode from the FSM state and the prioritised hazards.
    always_comb begin
        pc_wen       = 1'b0;
        if_id_wen    = 1'b0;
        id_ex_wen    = 1'b0;
        ex_mem_wen   = 1'b0;
        mem_wb_wen   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        pc_wen = 1'b0;
                    end else if (stall) begin
                        id_ex_wen    = 1'b1;
                        ex_mem_wen   = 1'b1;
                        mem_wb_wen   = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_wen      = 1'b1;
                        if_id_wen   = 1'b1;
                        id_ex_wen   = 1'b1;
                        ex_mem_wen  = 1'b1;
                        mem_wb_wen  = 1'b1;
                        if_id_flush = taken;
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        if_id_wen   = 1'b1;
                        id_ex_wen   = 1'b1;
                        ex_mem_wen  = 1'b1;
                        mem_wb_wen  = 1'b1;
                        if_id_flush = 1'b1;
                    end
                end
                default: begin
                    pc_wen = 1'b0;
                end
            endcase
        end
    end

    // Halt-drain FSM: accept HLT in RUN, count the drain down, then park in HALTED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            hlt       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_accept) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        if (drain_cnt == '0) begin
                            state <= HALTED;
                            hlt   <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                HALTED: begin
                    hlt <= 1'b1;
                end
                default: begin
                    state     <= RUN;
                    drain_cnt <= '0;
                    hlt       <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = (state == RUN) & ~mem_busy & stall;
    assign flush_evt = (state == RUN) & ~mem_busy & ~stall & taken;

    // Saturating event counters; only RUN-state events count, so HALTED freezes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_evt && !(&perf_stall_cnt)) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            if (flush_evt && !(&perf_flush_cnt)) begin
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// Control outputs are compared as one packed vector:
// {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen, if_id_flush, id_ex_bubble, hlt}.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW  = 4;
    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 16;

    localparam logic [7:0] C_OFF    = 8'b0000_0000;
    localparam logic [7:0] C_RUN    = 8'b1111_1000;
    localparam logic [7:0] C_STALL  = 8'b0011_1010;
    localparam logic [7:0] C_FLUSH  = 8'b1111_1100;
    localparam logic [7:0] C_DRAIN  = 8'b0111_1100;
    localparam logic [7:0] C_HALTED = 8'b0000_0001;

    logic                       clk;
    logic                       rst;
    logic                       id_valid;
    logic [NUM_SRC*REG_AW-1:0]  id_src;
    logic [NUM_SRC-1:0]         id_src_use;
    logic                       id_branch;
    logic                       id_br_taken;
    logic                       id_halt;
    logic                       ex_valid;
    logic                       ex_memread;
    logic                       ex_regwrite;
    logic                       ex_flag_set;
    logic [REG_AW-1:0]          ex_dst;
    logic [NUM_SRC*REG_AW-1:0]  ex_src;
    logic                       mem_valid;
    logic                       mem_regwrite;
    logic [REG_AW-1:0]          mem_dst;
    logic                       mem_busy;
    logic                       wb_regwrite;
    logic [REG_AW-1:0]          wb_dst;
    logic                       pc_wen;
    logic                       if_id_wen;
    logic                       id_ex_wen;
    logic                       ex_mem_wen;
    logic                       mem_wb_wen;
    logic                       if_id_flush;
    logic                       id_ex_bubble;
    logic [2*NUM_SRC-1:0]       fwd_sel;
    logic                       hlt;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0]           perf_stall_cnt;
    logic [CNT_W-1:0]           perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DRAIN_CYC(3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src(id_src), .id_src_use(id_src_use),
        .id_branch(id_branch), .id_br_taken(id_br_taken), .id_halt(id_halt),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_flag_set(ex_flag_set), .ex_dst(ex_dst), .ex_src(ex_src),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
        .mem_busy(mem_busy), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
        .pc_wen(pc_wen), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen),
        .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .fwd_sel(fwd_sel), .hlt(hlt)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next falling edge and drive an idle pipeline (rst unchanged).
    task automatic applyStimulus();
        @(negedge clk);
        id_valid     = 1'b0;
        id_src       = '0;
        id_src_use   = '0;
        id_branch    = 1'b0;
        id_br_taken  = 1'b0;
        id_halt      = 1'b0;
        ex_valid     = 1'b0;
        ex_memread   = 1'b0;
        ex_regwrite  = 1'b0;
        ex_flag_set  = 1'b0;
        ex_dst       = '0;
        ex_src       = '0;
        mem_valid    = 1'b0;
        mem_regwrite = 1'b0;
        mem_dst      = '0;
        mem_busy     = 1'b0;
        wb_regwrite  = 1'b0;
        wb_dst       = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic [7:0] expected);
        checkOutput(tag, {24'd0, pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
                          if_id_flush, id_ex_bubble, hlt}, {24'd0, expected});
    endtask

    // Set up an EX-stage LW R2 against an ID-stage ADD R5,R2,R4.
    task automatic setLoadUse();
        ex_valid    = 1'b1;
        ex_memread  = 1'b1;
        ex_regwrite = 1'b1;
        ex_dst      = 4'd2;
        id_valid    = 1'b1;
        id_src      = {4'd4, 4'd2};
        id_src_use  = 2'b11;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus();
        ex_src = {4'd3, 4'd3}; mem_valid = 1'b1; mem_regwrite = 1'b1; mem_dst = 4'd3;
        wb_regwrite = 1'b1; wb_dst = 4'd3; setLoadUse();
        #1;
        checkCtrl("reset_ctrl", C_OFF);
        checkOutput("reset_fwd", {28'd0, fwd_sel}, 32'h0);

        applyStimulus();
        rst = 1'b0;
        #1;
        checkCtrl("run_idle", C_RUN);

        // Forwarding
        applyStimulus();
        ex_src = {4'd3, 4'd3}; mem_valid = 1'b1; mem_regwrite = 1'b1; mem_dst = 4'd3;
        wb_regwrite = 1'b1; wb_dst = 4'd3;
        #1;
        checkOutput("fwd_mem_prio", {28'd0, fwd_sel}, 32'hA);
        mem_dst = 4'd0;
        #1;
        checkOutput("fwd_r0_mem", {28'd0, fwd_sel}, 32'h5);
        ex_src = {4'd5, 4'd3}; mem_dst = 4'd5;
        #1;
        checkOutput("fwd_mixed", {28'd0, fwd_sel}, 32'h9);
        ex_src = {4'd0, 4'd0}; mem_dst = 4'd0; wb_dst = 4'd0;
        #1;
        checkOutput("fwd_r0_wb", {28'd0, fwd_sel}, 32'h0);
        mem_valid = 1'b0; mem_dst = 4'd5; ex_src = {4'd5, 4'd5};
        #1;
        checkOutput("fwd_mem_invalid", {28'd0, fwd_sel}, 32'h0);

        // Load-use: one stall cycle then release
        applyStimulus();
        setLoadUse();
        #1;
        checkCtrl("loaduse_stall", C_STALL);
        applyStimulus();
        id_valid = 1'b1; id_src = {4'd4, 4'd2}; id_src_use = 2'b11;
        #1;
        checkCtrl("loaduse_release", C_RUN);
        applyStimulus();
        setLoadUse(); id_src_use = 2'b10;
        #1;
        checkCtrl("loaduse_unused_op", C_RUN);
        applyStimulus();
        setLoadUse(); ex_dst = 4'd0; id_src = {4'd4, 4'd0};
        #1;
        checkCtrl("loaduse_r0", C_RUN);

        // Flag hazard followed by a taken branch
        applyStimulus();
        ex_valid = 1'b1; ex_regwrite = 1'b1; ex_flag_set = 1'b1; ex_dst = 4'd7;
        id_valid = 1'b1; id_branch = 1'b1;
        #1;
        checkCtrl("flag_stall", C_STALL);
        applyStimulus();
        id_valid = 1'b1; id_branch = 1'b1; id_br_taken = 1'b1;
        #1;
        checkCtrl("branch_flush", C_FLUSH);
`ifdef PIPE_CTRL_PERF_EN
        applyStimulus();
        #1;
        checkOutput("perf_stall", {16'd0, perf_stall_cnt}, 32'd2);
        checkOutput("perf_flush", {16'd0, perf_flush_cnt}, 32'd1);
`endif

        // Taken branch during a stall is ignored
        applyStimulus();
        ex_valid = 1'b1; ex_flag_set = 1'b1;
        id_valid = 1'b1; id_branch = 1'b1; id_br_taken = 1'b1;
        #1;
        checkCtrl("branch_in_stall", C_STALL);

        // Freeze for 3 cycles over a load-use, then exactly one stall
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            setLoadUse(); mem_busy = 1'b1; id_br_taken = 1'b1;
            #1;
            checkCtrl($sformatf("freeze_%0d", i), C_OFF);
        end
        applyStimulus();
        setLoadUse();
        #1;
        checkCtrl("freeze_then_stall", C_STALL);
        applyStimulus();
        #1;
        checkCtrl("freeze_done", C_RUN);

        // HLT is not accepted while a stall is pending
        applyStimulus();
        setLoadUse(); id_halt = 1'b1;
        #1;
        checkCtrl("halt_blocked", C_STALL);
        applyStimulus();
        #1;
        checkCtrl("halt_blocked_run", C_RUN);

        // Halt drain: accept at edge N, hlt from N+3
        applyStimulus();
        id_valid = 1'b1; id_halt = 1'b1;
        #1;
        checkCtrl("halt_accept", C_RUN);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            #1;
            checkCtrl($sformatf("drain_%0d", i), C_DRAIN);
        end
        applyStimulus();
        id_valid = 1'b1; id_br_taken = 1'b1;
        #1;
        checkCtrl("halted", C_HALTED);
        applyStimulus();
        #1;
        checkCtrl("halted_hold", C_HALTED);

        // Asynchronous reset out of HALTED
        applyStimulus();
        rst = 1'b1;
        #1;
        checkCtrl("reset_halted", C_OFF);
        applyStimulus();
        rst = 1'b0;
        #1;
        checkCtrl("after_reset", C_RUN);

        // Halt drain extended by two busy cycles: hlt from N+5
        applyStimulus();
        id_valid = 1'b1; id_halt = 1'b1;
        #1;
        checkCtrl("halt2_accept", C_RUN);
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            mem_busy = 1'b1;
            #1;
            checkCtrl($sformatf("drain_busy_%0d", i), C_OFF);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            #1;
            checkCtrl($sformatf("drain2_%0d", i), C_DRAIN);
        end
        applyStimulus();
        #1;
        checkCtrl("halted2", C_HALTED);

        // Reset mid-DRAIN returns to RUN
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        id_valid = 1'b1; id_halt = 1'b1;
        #1;
        checkCtrl("halt3_accept", C_RUN);
        applyStimulus();
        rst = 1'b1;
        #1;
        checkCtrl("reset_drain", C_OFF);
        applyStimulus();
        rst = 1'b0;
        #1;
        checkCtrl("reset_drain_run", C_RUN);
        applyStimulus();
        #1;
        checkCtrl("reset_drain_stay", C_RUN);
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("perf_stall_reset", {16'd0, perf_stall_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
